// File: rtl/alu_share_arb_if.sv
// Handshake and shared-ALU bundle for alu_share_arb: two requesters, their responses, and the ALU hookup.
interface alu_share_arb_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic [3:0]  req0_func;
    logic [3:0]  req1_func;
    logic        req0_ready;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;
    logic        busy;

    // requesters plus the external ALU
    modport master (
        output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        output req0_func, req1_func, rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  alu_op1, alu_op2, alu_func, busy
    );

    // the arbiter
    modport slave (
        input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        input  req0_func, req1_func, rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output alu_op1, alu_op2, alu_func, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one combinational ALU; round-robin by default,
// fixed priority to requester 0 when ALU_SHARE_ARB_FIXED_PRIO_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; grants one and pulses its ready
// EXEC  | latched operands drive the ALU; result captured at the edge
// RESP  | rsp_data held, granted rsp valid high until its ready
module alu_share_arb (
    input  logic             clk,
    input  logic             rst,
    alu_share_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [3:0]  func_q;
    logic        gid_q;
    logic [31:0] rsp_data_q;

    logic        pick1;
    logic        accept;
    logic        done;
    logic        ready0;
    logic        ready1;
    logic        rspv0;
    logic        rspv1;
    logic [31:0] alu_op1_d;
    logic [31:0] alu_op2_d;
    logic [3:0]  alu_func_d;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    always_comb begin
        pick1 = bus.req1_valid && !bus.req0_valid;
    end
`else
    logic ptr_q;

    // pointer side wins a tie; a lone request wins regardless
    always_comb begin
        pick1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (done) begin
            ptr_q <= ~gid_q;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        done       = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        rspv0      = 1'b0;
        rspv1      = 1'b0;
        alu_op1_d  = 32'd0;
        alu_op2_d  = 32'd0;
        alu_func_d = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept  = 1'b1;
                    ready0  = ~pick1;
                    ready1  = pick1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op1_d  = op1_q;
                alu_op2_d  = op2_q;
                alu_func_d = func_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                rspv0 = ~gid_q;
                rspv1 = gid_q;
                if (gid_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // reset overrides everything visible and blocks any acceptance
        if (rst) begin
            accept = 1'b0;
            done   = 1'b0;
            ready0 = 1'b0;
            ready1 = 1'b0;
            rspv0  = 1'b0;
            rspv1  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            func_q     <= 4'd0;
            gid_q      <= 1'b0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op1_q  <= pick1 ? bus.req1_op1  : bus.req0_op1;
                op2_q  <= pick1 ? bus.req1_op2  : bus.req0_op2;
                func_q <= pick1 ? bus.req1_func : bus.req0_func;
                gid_q  <= pick1;
            end
            if (state_q == S_EXEC) begin
                rsp_data_q <= bus.alu_out;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rspv0;
    assign bus.rsp1_valid = rspv1;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.alu_op1    = alu_op1_d;
    assign bus.alu_op2    = alu_op2_d;
    assign bus.alu_func   = alu_func_d;
    assign bus.busy       = (state_q != S_IDLE) && !rst;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU on the shared port.
module tb_alu_share_arb;
    localparam logic [3:0] F_SLL = 4'd0;
    localparam logic [3:0] F_SRL = 4'd1;
    localparam logic [3:0] F_SRA = 4'd2;
    localparam logic [3:0] F_ADD = 4'd3;
    localparam logic [3:0] F_SUB = 4'd4;
    localparam logic [3:0] F_AND = 4'd5;
    localparam logic [3:0] F_OR  = 4'd6;
    localparam logic [3:0] F_XOR = 4'd7;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_share_arb_if bus ();

    alu_share_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_func)
            F_SLL:   bus.alu_out = bus.alu_op1 << bus.alu_op2[4:0];
            F_SRL:   bus.alu_out = bus.alu_op1 >> bus.alu_op2[4:0];
            F_SRA:   bus.alu_out = $unsigned($signed(bus.alu_op1) >>> bus.alu_op2[4:0]);
            F_ADD:   bus.alu_out = bus.alu_op1 + bus.alu_op2;
            F_SUB:   bus.alu_out = bus.alu_op1 - bus.alu_op2;
            F_AND:   bus.alu_out = bus.alu_op1 & bus.alu_op2;
            F_OR:    bus.alu_out = bus.alu_op1 | bus.alu_op2;
            F_XOR:   bus.alu_out = bus.alu_op1 ^ bus.alu_op2;
            default: bus.alu_out = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_op1 = 0; bus.req0_op2 = 0; bus.req0_func = 0;
        bus.req1_op1 = 0; bus.req1_op2 = 0; bus.req1_func = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        bus.req0_valid = 1; bus.req0_op1 = 32'd9; bus.req0_func = F_ADD;
        tick();
        @(negedge clk);
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", bus.req0_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL rst_rspv got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); end
        tick();
        rst = 0;
        bus.req0_valid = 0;
        @(negedge clk);
        total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.rsp_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
        tick();
    endtask

    task automatic test_single();
        bus.req0_valid = 1; bus.req0_op1 = 32'd5; bus.req0_op2 = 32'd7; bus.req0_func = F_ADD;
        @(negedge clk);
        total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL single_accept got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        tick();
        bus.req0_valid = 0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
        total++; if (bus.alu_op1 !== 32'd5 || bus.alu_op2 !== 32'd7 || bus.alu_func !== F_ADD) begin bad++; $display("FAIL single_alu got=%h,%h,%h exp=5,7,3", bus.alu_op1, bus.alu_op2, bus.alu_func); end
        total++; if (bus.rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%b exp=0", bus.rsp0_valid); end
        tick();
        bus.rsp0_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rspv got=%b%b exp=10", bus.rsp0_valid, bus.rsp1_valid); end
        total++; if (bus.rsp_data !== 32'd12) begin bad++; $display("FAIL single_data got=%0d exp=12", bus.rsp_data); end
        tick();
        bus.rsp0_ready = 0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_done got busy=%b rspv=%b exp=0,0", bus.busy, bus.rsp0_valid); end
    endtask

    task automatic test_both();
        rst = 1;
        tick();
        rst = 0;
        bus.req0_valid = 1; bus.req0_op1 = 32'd10; bus.req0_op2 = 32'd3; bus.req0_func = F_SUB;
        bus.req1_valid = 1; bus.req1_op1 = 32'hF0; bus.req1_op2 = 32'h3C; bus.req1_func = F_AND;
        @(negedge clk);
        total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL both_first got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        tick();
        bus.req0_valid = 0;
        @(negedge clk);
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL both_exec_ready1 got=%b exp=0", bus.req1_ready); end
        tick();
        bus.rsp1_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 32'd7) begin bad++; $display("FAIL both_rsp0 got v=%b d=%h exp 1,7", bus.rsp0_valid, bus.rsp_data); end
        tick();
        bus.rsp1_ready = 0;
        bus.rsp0_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp0_valid !== 1'b1) begin bad++; $display("FAIL both_rsp1ready_ignored got=%b exp=1", bus.rsp0_valid); end
        tick();
        bus.rsp0_ready = 0;
        @(negedge clk);
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL both_second got=%b exp=1", bus.req1_ready); end
        tick();
        bus.req1_valid = 0;
        tick();
        bus.rsp1_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'h30) begin bad++; $display("FAIL both_rsp1 got v=%b%b d=%h exp 01,30", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data); end
        tick();
        bus.rsp1_ready = 0;
    endtask

    task automatic test_again();
        bus.req0_valid = 1; bus.req0_op1 = 32'h0F; bus.req0_op2 = 32'hF0; bus.req0_func = F_OR;
        bus.req1_valid = 1; bus.req1_op1 = 32'd3;  bus.req1_op2 = 32'd5;  bus.req1_func = F_XOR;
        @(negedge clk);
        total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL again_winner got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        bus.rsp0_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 32'hFF) begin bad++; $display("FAIL again_rsp got v=%b d=%h exp 1,ff", bus.rsp0_valid, bus.rsp_data); end
        tick();
        bus.rsp0_ready = 0;
    endtask

    task automatic test_stall();
        bus.req0_valid = 1; bus.req0_op1 = 32'd1; bus.req0_op2 = 32'd4; bus.req0_func = F_SLL;
        @(negedge clk);
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", bus.req0_ready); end
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_op1 = 32'd3; bus.req1_op2 = 32'd5; bus.req1_func = F_XOR;
        @(negedge clk);
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL stall_exec_ready1 got=%b exp=0", bus.req1_ready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 32'd16) begin bad++; $display("FAIL stall_hold[%0d] got v=%b d=%h exp 1,10", i, bus.rsp0_valid, bus.rsp_data); end
            total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL stall_ready1[%0d] got=%b exp=0", i, bus.req1_ready); end
            total++; if (bus.alu_op1 !== 32'd0 || bus.alu_op2 !== 32'd0 || bus.alu_func !== 4'd0) begin bad++; $display("FAIL stall_alu[%0d] got=%h,%h,%h exp=0", i, bus.alu_op1, bus.alu_op2, bus.alu_func); end
            tick();
        end
        bus.rsp0_ready = 1;
        @(negedge clk);
        total++; if (bus.req1_ready !== 1'b0 || bus.rsp0_valid !== 1'b1) begin bad++; $display("FAIL stall_handshake got r1=%b v0=%b exp 0,1", bus.req1_ready, bus.rsp0_valid); end
        tick();
        bus.rsp0_ready = 0;
        @(negedge clk);
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL stall_req1_after got=%b exp=1", bus.req1_ready); end
        tick();
        bus.req1_valid = 0;
        tick();
        bus.rsp1_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== 32'd6) begin bad++; $display("FAIL stall_rsp1 got v=%b d=%h exp 1,6", bus.rsp1_valid, bus.rsp_data); end
        tick();
        bus.rsp1_ready = 0;
    endtask

    task automatic test_rst_exec();
        bus.req1_valid = 1; bus.req1_op1 = 32'h8000_0000; bus.req1_op2 = 32'd4; bus.req1_func = F_SRA;
        @(negedge clk);
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL rstx_accept got=%b exp=1", bus.req1_ready); end
        tick();
        bus.req1_valid = 0;
        bus.rsp1_ready = 1;
        rst = 1;
        @(negedge clk);
        total++; if (bus.alu_func !== F_SRA || bus.alu_op1 !== 32'h8000_0000) begin bad++; $display("FAIL rstx_exec_alu got=%h,%h exp=2,80000000", bus.alu_func, bus.alu_op1); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstx_busy_in_rst got=%b exp=0", bus.busy); end
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_data !== 32'd0) begin bad++; $display("FAIL rstx_after[%0d] got v=%b b=%b d=%h exp 0,0,0", i, bus.rsp1_valid, bus.busy, bus.rsp_data); end
            tick();
        end
        bus.rsp1_ready = 0;
    endtask

    task automatic test_alu_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (bus.alu_op1 !== 32'd0 || bus.alu_op2 !== 32'd0 || bus.alu_func !== 4'd0) begin bad++; $display("FAIL idle_alu[%0d] got=%h,%h,%h exp=0", i, bus.alu_op1, bus.alu_op2, bus.alu_func); end
            total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL idle_ready[%0d] got=%b%b exp=00", i, bus.req0_ready, bus.req1_ready); end
            tick();
        end
        bus.req0_valid = 1; bus.req0_op1 = 32'hAB; bus.req0_op2 = 32'hCD; bus.req0_func = F_SRL;
        @(negedge clk);
        total++; if (bus.alu_op1 !== 32'd0 || bus.alu_func !== 4'd0) begin bad++; $display("FAIL idle_alu_accept got=%h,%h exp=0", bus.alu_op1, bus.alu_func); end
        tick();
        bus.req0_valid = 0;
        tick();
        bus.rsp0_ready = 1;
        @(negedge clk);
        total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL idle_srl_data got=%h exp=0", bus.rsp_data); end
        tick();
        bus.rsp0_ready = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_both();
        test_again();
        test_stall();
        test_rst_exec();
        test_alu_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-004 SHALL have ports req0_op1, req0_op2, req1_op1, req1_op2  input  32  operands per requester.
REQ-005 SHALL have ports req0_func / req1_func  input  4  ALU operation code per requester, using the Parameters.v encodings.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  one-cycle acceptance pulse to requester N.
REQ-007 SHALL have ports rsp0_valid / rsp1_valid  output  1  result available for requester N.
REQ-008 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
REQ-009 SHALL have port rsp_data  output  32  registered result, shared by both responders.
REQ-010 SHALL have ports alu_op1 / alu_op2  output  32  and alu_func  output  4  driving the shared ALU.
REQ-011 SHALL have port alu_out  input  32  combinational ALU result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-014 In IDLE with at least one reqN_valid, SHALL grant exactly one requester, pulse its reqN_ready for that cycle, latch its op1/op2/func and grant id, and go to EXEC.
REQ-015 In IDLE with no valid request, SHALL stay in IDLE with both ready outputs low.
REQ-016 In EXEC, SHALL drive alu_op1/alu_op2/alu_func from the latched registers, capture alu_out into rsp_data at the clock edge, and go to RESP.
REQ-017 In RESP, SHALL hold rspG_valid high (G = granted id) with rsp_data stable until rspG_ready is sampled high, then go to IDLE.
REQ-018 The non-granted rsp valid SHALL stay low, and its rsp_ready SHALL be ignored.
REQ-019 Latency SHALL be: acceptance at cycle T, rsp valid at T+2; minimum issue interval 3 cycles.
REQ-020 Outside EXEC, SHALL drive alu_op1 = 0, alu_op2 = 0, alu_func = 0.
REQ-021 func codes SHALL be passed unmodified; an undefined code yields whatever the ALU returns (0 by its default).
REQ-022 Round-robin: a priority pointer SHALL start at requester 0 and toggle to the non-granted side after each completed RESP handshake.
REQ-023 On simultaneous valid requests, the pointer side SHALL win; with a single valid request, that request SHALL win regardless of the pointer.
REQ-024 reqN_valid deasserting before acceptance SHALL be legal; no state change results.
REQ-025 Requester inputs SHALL be ignored outside IDLE, and ready SHALL never assert in EXEC or RESP.
REQ-026 In RESP, rspG_ready arriving in the same cycle rspG_valid first rises SHALL complete the handshake that cycle.

Reset
REQ-027 rst high at a clock edge SHALL force: state IDLE, pointer 0, rsp_data 0, latched operands/func/grant 0.
REQ-028 While rst is high, SHALL hold all ready, rsp valid and busy outputs at 0.
REQ-029 rst during EXEC or RESP SHALL silently discard the in-flight operation and issue no response.

Configuration
REQ-030 Macro ALU_SHARE_ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-031 With ALU_SHARE_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests, and the pointer register SHALL be absent.
REQ-032 Without ALU_SHARE_ARB_FIXED_PRIO_EN, round-robin per REQ-022/023 SHALL apply.

Verification
REQ-033 Bench SHALL cover: req0 only, func=ADD, op1=5, op2=7 -> req0_ready at T, rsp0_valid at T+2, rsp_data=12, rsp1_valid=0.
REQ-034 Bench SHALL cover: both valid from reset (req0 SUB 10,3; req1 AND 0xF0,0x3C) -> req0 served first, rsp_data=7; then req1 served, rsp_data=0x30.
REQ-035 Bench SHALL cover: after REQ-034, both valid again -> req0 wins without the macro; req0 wins with the macro defined.
REQ-036 Bench SHALL cover: rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp_data (SLL 1,4 = 16) stay stable; req1 not readied until handshake completes.
REQ-037 Bench SHALL cover: rst asserted in EXEC of req1 SRA 0x80000000,4 -> next cycle state IDLE, no rsp1_valid, rsp_data=0.
REQ-038 Bench SHALL cover: outside EXEC -> alu_op1, alu_op2 and alu_func observed 0 every cycle.
